// File: rtl/counter_pkg.sv
// Shared defaults and count type for the sequencing step counters.
package counter_pkg;

    localparam int COUNT_WIDTH = 4;
    localparam int COUNT_MAX   = 12;

    typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/wrap_counter.sv
// Free-running modulo counter: steps 0..MAX_COUNT and wraps to 0. Used as the
// phase step counter of the neural-network datapath controller.
module wrap_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNT_WIDTH,
    parameter int MAX_COUNT = COUNT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Reject configurations whose last value cannot be represented.
    if (MAX_COUNT < 1 || MAX_COUNT >= (1 << WIDTH)) begin : g_bad_params
        $fatal(1, "wrap_counter: MAX_COUNT=%0d illegal for WIDTH=%0d", MAX_COUNT, WIDTH);
    end

    logic [WIDTH-1:0] next_count;

    // Anything at or above MAX_COUNT (including upset values) goes back to 0.
    always_comb begin
        next_count = '0;
        if (out < MAX_VAL) begin
            next_count = out + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else begin
            out <= next_count;
        end
    end

endmodule : wrap_counter

// File: tb/tb_wrap_counter.sv
// Bench for wrap_counter: default (4-bit, max 12) and a 3-bit, max 5 variant.
`timescale 1ns/1ps
module tb_wrap_counter;

    logic       clk;
    logic       reset;
    logic [3:0] out_a;
    logic [2:0] out_b;

    int checks;
    int errors;
    int n_edges;
    logic [3:0] exp_q[$];
    logic [2:0] exp_b_q[$];

    wrap_counter #(.WIDTH(4), .MAX_COUNT(12)) dut_a (
        .clk   (clk),
        .reset (reset),
        .out   (out_a)
    );

    wrap_counter #(.WIDTH(3), .MAX_COUNT(5)) dut_b (
        .clk   (clk),
        .reset (reset),
        .out   (out_b)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a counter of edges since release, reduced modulo the period.
    task automatic tick();
        logic [3:0] ea;
        logic [2:0] eb;
        @(posedge clk);
        n_edges++;
        exp_q.push_back(4'(n_edges % 13));
        exp_b_q.push_back(3'(n_edges % 6));
        @(negedge clk);
        ea = exp_q.pop_front();
        eb = exp_b_q.pop_front();
        check("count_a", int'(out_a), int'(ea));
        check("count_b", int'(out_b), int'(eb));
        check("range_a", int'(out_a <= 4'd12), 1);
    endtask

    // Asserts reset from the current (between-edges) time, holds it for
    // hold_cycles edges, then releases on a falling edge.
    task automatic do_reset(input int hold_cycles);
        reset = 1'b0;
        #1;
        check("async_clear_a", int'(out_a), 0);
        check("async_clear_b", int'(out_b), 0);
        repeat (hold_cycles) begin
            @(negedge clk);
            check("held_a", int'(out_a), 0);
            check("held_b", int'(out_b), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        n_edges = 0;
        exp_q.delete();
        exp_b_q.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_edges = 0;
        reset   = 1'b0;

        // Power-up reset
        repeat (2) @(negedge clk);
        check("reset_a", int'(out_a), 0);
        check("reset_b", int'(out_b), 0);
        reset = 1'b1;

        // Count up 1..12, wrap to 0, then one more full period
        repeat (12 + 1 + 13) tick();
        check("after_two_periods_a", int'(out_a), 0);

        // Reset mid-count at 7, released, first edge loads 1
        @(negedge clk);
        reset = 1'b0;
        reset = 1'b1;
        do_reset(0);
        repeat (7) tick();
        check("at_seven", int'(out_a), 7);
        #2;
        do_reset(2);
        tick();
        check("first_after_release", int'(out_a), 1);

        // Reset from MAX_COUNT
        repeat (11) tick();
        check("at_max", int'(out_a), 12);
        #3;
        do_reset(1);

        // Randomized run lengths and reset points
        for (int i = 0; i < 10; i++) begin
            int run_len;
            run_len = int'($urandom_range(1, 40));
            repeat (run_len) tick();
            @(negedge clk);
            n_edges++;
            exp_q.push_back(4'(n_edges % 13));
            exp_b_q.push_back(3'(n_edges % 6));
            void'(exp_q.pop_front());
            void'(exp_b_q.pop_front());
            check("rand_pre_reset_a", int'(out_a), n_edges % 13);
            #($urandom_range(1, 3));
            do_reset(int'($urandom_range(0, 3)));
        end
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wrap_counter
